// File: rtl/pipe_ctrl_pkg.sv
// pipe_pkg: shared definitions for the pipeline controller.
//   state_t  - controller FSM states (RUN, MC_WAIT)
//   FWD_RF   - EX operand comes from the register file
//   FWD_MEM  - EX operand comes from the EX/MEM result
//   FWD_WB   - EX operand comes from the MEM/WB result
package pipe_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/pipe_ctrl_fwd_sel.sv
// fwd_sel: picks the source of one EX operand.
// Ports:
//   rs            - source register of the operand in EX
//   mem_rd        - destination register in MEM
//   mem_reg_write - MEM instruction writes a register
//   mem_mem_read  - MEM instruction is a load (its data is not ready yet)
//   wb_rd         - destination register in WB
//   wb_reg_write  - WB instruction writes a register
//   sel           - FWD_RF / FWD_MEM / FWD_WB
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    output logic [1:0]        sel
);

    // The youngest producer wins. A load sitting in MEM matches but cannot
    // forward; it still shadows the older WB value, so the register file is
    // selected (the load-use stall keeps this case from being consumed).
    always_comb begin
        sel = FWD_RF;
        if (rs != '0 && mem_reg_write && mem_rd == rs) begin
            sel = mem_mem_read ? FWD_RF : FWD_MEM;
        end else if (rs != '0 && wb_reg_write && wb_rd == rs) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: fetch PC, stall/flush/bubble generation and operand forwarding
// for a 5-stage pipeline with branches resolved in ID and multi-cycle EX ops.
// Build option: PIPE_CTRL_FWD_EN enables forwarding; without it the forward
// selects are tied to the register file and any RAW dependency on EX or MEM
// stalls ID.
// Ports:
//   clk_i, rst_i                  - clock, synchronous active-high reset
//   id_rs1_i/id_rs2_i, id_use_*   - ID sources and their valid flags
//   id_branch_i                   - ID holds a branch/jalr resolved in ID
//   ex_rs1_i/ex_rs2_i             - EX sources (forwarding)
//   ex_rd_i/mem_rd_i/wb_rd_i      - destinations in EX/MEM/WB
//   *_reg_write_i, *_mem_read_i   - stage control flags
//   ex_multi_i                    - multi-cycle op entered EX this cycle
//   redirect_i, redirect_pc_i     - taken control transfer from ID
//   pc_o                          - fetch address
//   stall_o, ifid_flush_o, idex_bubble_o, exmem_bubble_o - pipeline controls
//   fwd_a_o, fwd_b_o              - EX operand selects
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              id_branch_i,
    input  logic [REG_AW-1:0] ex_rs1_i,
    input  logic [REG_AW-1:0] ex_rs2_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              ex_reg_write_i,
    input  logic              ex_mem_read_i,
    input  logic              mem_reg_write_i,
    input  logic              mem_mem_read_i,
    input  logic              wb_reg_write_i,
    input  logic              ex_multi_i,
    input  logic              redirect_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    output logic [PC_W-1:0]   pc_o,
    output logic              stall_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic              exmem_bubble_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o
);

    state_t          state;
    logic [3:0]      mc_cnt;
    logic [PC_W-1:0] pc_q;

    logic rs1_live;
    logic rs2_live;
    logic match_ex;
    logic match_mem;
    logic hazard;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    // x0 is hard-wired zero, so it never creates a dependency.
    assign rs1_live  = id_use_rs1_i && (id_rs1_i != '0);
    assign rs2_live  = id_use_rs2_i && (id_rs2_i != '0);
    assign match_ex  = (rs1_live && id_rs1_i == ex_rd_i) ||
                       (rs2_live && id_rs2_i == ex_rd_i);
    assign match_mem = (rs1_live && id_rs1_i == mem_rd_i) ||
                       (rs2_live && id_rs2_i == mem_rd_i);

`ifdef PIPE_CTRL_FWD_EN
    // With forwarding only a load in EX, or a branch comparing in ID against
    // a value not yet available, has to wait.
    assign hazard = (match_ex && ex_mem_read_i) ||
                    (id_branch_i && ((match_ex && ex_reg_write_i) ||
                                     (match_mem && mem_mem_read_i)));

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs            (ex_rs1_i),
        .mem_rd        (mem_rd_i),
        .mem_reg_write (mem_reg_write_i),
        .mem_mem_read  (mem_mem_read_i),
        .wb_rd         (wb_rd_i),
        .wb_reg_write  (wb_reg_write_i),
        .sel           (sel_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs            (ex_rs2_i),
        .mem_rd        (mem_rd_i),
        .mem_reg_write (mem_reg_write_i),
        .mem_mem_read  (mem_mem_read_i),
        .wb_rd         (wb_rd_i),
        .wb_reg_write  (wb_reg_write_i),
        .sel           (sel_b)
    );
`else
    // Without forwarding every in-flight producer in EX or MEM blocks ID; WB
    // is assumed to write the register file before ID reads it.
    logic unused_no_fwd;

    assign hazard = (match_ex && (ex_reg_write_i || ex_mem_read_i)) ||
                    (match_mem && mem_reg_write_i);
    assign sel_a  = FWD_RF;
    assign sel_b  = FWD_RF;
    assign unused_no_fwd = ^{ex_rs1_i, ex_rs2_i, wb_rd_i, wb_reg_write_i,
                             mem_mem_read_i, id_branch_i};
`endif

    // Controller state and fetch PC. MC_WAIT freezes everything upstream of
    // EX for MC_LAT-1 cycles; in RUN a hazard holds the PC, otherwise an ID
    // redirect or the sequential successor is fetched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= RUN;
            mc_cnt <= '0;
            pc_q   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_multi_i) begin
                        state  <= MC_WAIT;
                        mc_cnt <= 4'(MC_LAT - 2);
                    end
                    if (!hazard) begin
                        pc_q <= redirect_i ? redirect_pc_i : pc_q + PC_W'(1);
                    end
                end
                MC_WAIT: begin
                    if (mc_cnt == '0) begin
                        state <= RUN;
                    end else begin
                        mc_cnt <= mc_cnt - 4'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Pipeline controls follow the current state and inputs; reset forces
    // every output low in the reset cycle itself.
    assign pc_o           = rst_i ? '0 : pc_q;
    assign stall_o        = !rst_i && (state == MC_WAIT || hazard);
    assign idex_bubble_o  = !rst_i && state == RUN && hazard;
    assign exmem_bubble_o = !rst_i && state == MC_WAIT;
    assign ifid_flush_o   = !rst_i && state == RUN && !hazard && redirect_i;
    assign fwd_a_o        = rst_i ? FWD_RF : sel_a;
    assign fwd_b_o        = rst_i ? FWD_RF : sel_b;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl (PC_W=8,
// REG_AW=5, MC_LAT=4). Expectations follow PIPE_CTRL_FWD_EN if defined.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, id_branch;
    logic       ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read;
    logic       wb_reg_write, ex_multi, redirect;
    logic [7:0] redirect_pc;
    logic [7:0] pc;
    logic       stall, ifid_flush, idex_bubble, exmem_bubble;
    logic [1:0] fwd_a, fwd_b;

    int         check_count = 0;
    int         error_count = 0;
    logic [7:0] exp_pc;
    logic       fwd_on;

    pipe_ctrl #(.PC_W(8), .REG_AW(5), .MC_LAT(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .id_rs1_i        (id_rs1),
        .id_rs2_i        (id_rs2),
        .id_use_rs1_i    (id_use_rs1),
        .id_use_rs2_i    (id_use_rs2),
        .id_branch_i     (id_branch),
        .ex_rs1_i        (ex_rs1),
        .ex_rs2_i        (ex_rs2),
        .ex_rd_i         (ex_rd),
        .mem_rd_i        (mem_rd),
        .wb_rd_i         (wb_rd),
        .ex_reg_write_i  (ex_reg_write),
        .ex_mem_read_i   (ex_mem_read),
        .mem_reg_write_i (mem_reg_write),
        .mem_mem_read_i  (mem_mem_read),
        .wb_reg_write_i  (wb_reg_write),
        .ex_multi_i      (ex_multi),
        .redirect_i      (redirect),
        .redirect_pc_i   (redirect_pc),
        .pc_o            (pc),
        .stall_o         (stall),
        .ifid_flush_o    (ifid_flush),
        .idex_bubble_o   (idex_bubble),
        .exmem_bubble_o  (exmem_bubble),
        .fwd_a_o         (fwd_a),
        .fwd_b_o         (fwd_b)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Returns every input to an idle, dependency-free value.
    task automatic clearInputs();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_use_rs1, id_use_rs2, id_branch} = '0;
        {ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read} = '0;
        {wb_reg_write, ex_multi, redirect} = '0;
        redirect_pc = '0;
    endtask

    // Presents the ID-stage instruction fields.
    task automatic applyStimulus(input logic [4:0] rs1, input logic use1,
                                 input logic [4:0] rs2, input logic use2,
                                 input logic branch);
        id_rs1 = rs1; id_use_rs1 = use1;
        id_rs2 = rs2; id_use_rs2 = use2;
        id_branch = branch;
        #1;
    endtask

    // Advances one clock and samples 1 time unit after the rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef PIPE_CTRL_FWD_EN
        fwd_on = 1'b1;
`else
        fwd_on = 1'b0;
`endif
        clearInputs();
        rst = 1'b1;
        ex_multi = 1'b1;
        redirect = 1'b1;
        stepCycle();
        checkOutput("rst_pc", pc, 0);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_flush", ifid_flush, 0);
        checkOutput("rst_exmem", exmem_bubble, 0);
        clearInputs();
        rst = 1'b0;
        #1;
        checkOutput("post_rst_pc", pc, 0);

        // Sequential fetch 1..5
        exp_pc = 8'd0;
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            exp_pc = exp_pc + 8'd1;
            checkOutput("seq_pc", pc, 32'(exp_pc));
        end

        // Redirect to 0x40, then to 0xFF and wrap to 0
        redirect = 1'b1; redirect_pc = 8'h40;
        #1;
        checkOutput("redir_flush", ifid_flush, 1);
        checkOutput("redir_stall", stall, 0);
        stepCycle();
        checkOutput("redir_pc", pc, 32'h40);
        redirect_pc = 8'hFF;
        stepCycle();
        checkOutput("redir_ff_pc", pc, 32'hFF);
        redirect = 1'b0;
        #1;
        checkOutput("no_redir_flush", ifid_flush, 0);
        stepCycle();
        checkOutput("wrap_pc", pc, 0);

        // Load-use on rs1 with a concurrent redirect: stalled, redirect ignored
        ex_rd = 5'd5; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
        redirect = 1'b1; redirect_pc = 8'h40;
        applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        checkOutput("lu_stall", stall, 1);
        checkOutput("lu_idex", idex_bubble, 1);
        checkOutput("lu_flush", ifid_flush, 0);
        checkOutput("lu_exmem", exmem_bubble, 0);
        stepCycle();
        checkOutput("lu_pc_held", pc, 0);
        clearInputs();
        #1;
        checkOutput("lu_release", stall, 0);
        stepCycle();
        checkOutput("lu_pc_next", pc, 1);

        // x0 and unused sources never stall
        ex_rd = 5'd0; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
        applyStimulus(5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        checkOutput("x0_stall", stall, 0);
        ex_rd = 5'd5;
        applyStimulus(5'd0, 1'b0, 5'd5, 1'b0, 1'b0);
        checkOutput("unused_rs2_stall", stall, 0);
        applyStimulus(5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        checkOutput("lu_rs2_stall", stall, 1);
        clearInputs();

        // ALU result in EX: branch must stall; plain use stalls only w/o fwd
        ex_rd = 5'd7; ex_reg_write = 1'b1;
        applyStimulus(5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        checkOutput("alu_dep_stall", stall, fwd_on ? 32'd0 : 32'd1);
        applyStimulus(5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        checkOutput("br_ex_stall", stall, 1);
        clearInputs();
        mem_rd = 5'd9; mem_reg_write = 1'b1; mem_mem_read = 1'b1;
        applyStimulus(5'd9, 1'b1, 5'd0, 1'b0, 1'b1);
        checkOutput("br_memload_stall", stall, 1);
        clearInputs();

        // Multi-cycle op, MC_LAT=4: three stalled cycles, redirect ignored
        #1;
        exp_pc = pc;
        ex_multi = 1'b1;
        #1;
        checkOutput("mc_entry_stall", stall, 0);
        stepCycle();
        ex_multi = 1'b0;
        redirect = 1'b1; redirect_pc = 8'h80;
        exp_pc = exp_pc + 8'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("mc_stall", stall, 1);
            checkOutput("mc_exmem", exmem_bubble, 1);
            checkOutput("mc_flush", ifid_flush, 0);
            checkOutput("mc_pc", pc, 32'(exp_pc));
            stepCycle();
        end
        checkOutput("mc_done_stall", stall, 0);
        checkOutput("mc_done_exmem", exmem_bubble, 0);
        checkOutput("mc_done_flush", ifid_flush, 1);
        clearInputs();

        // Forward selects
        ex_rs1 = 5'd3; mem_rd = 5'd3; mem_reg_write = 1'b1;
        wb_rd = 5'd3; wb_reg_write = 1'b1;
        applyStimulus(5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        checkOutput("fwd_a_mem", fwd_a, fwd_on ? 32'd1 : 32'd0);
        checkOutput("fwd_dep_stall", stall, fwd_on ? 32'd0 : 32'd1);
        mem_rd = 5'd4;
        ex_rs2 = 5'd3;
        #1;
        checkOutput("fwd_a_wb", fwd_a, fwd_on ? 32'd2 : 32'd0);
        checkOutput("fwd_b_wb", fwd_b, fwd_on ? 32'd2 : 32'd0);
        mem_rd = 5'd3; mem_mem_read = 1'b1;
        #1;
        checkOutput("fwd_a_memload", fwd_a, 0);
        clearInputs();
        mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        #1;
        checkOutput("fwd_a_x0", fwd_a, 0);
        checkOutput("fwd_b_x0", fwd_b, 0);
        clearInputs();

        // Reset while in MC_WAIT
        ex_multi = 1'b1;
        stepCycle();
        ex_multi = 1'b0;
        #1;
        checkOutput("mc2_stall", stall, 1);
        rst = 1'b1;
        #1;
        checkOutput("mc2_rst_stall", stall, 0);
        checkOutput("mc2_rst_exmem", exmem_bubble, 0);
        stepCycle();
        rst = 1'b0;
        #1;
        checkOutput("mc2_after_stall", stall, 0);
        checkOutput("mc2_after_pc", pc, 0);
        stepCycle();
        checkOutput("mc2_run_pc", pc, 1);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter PC_W, default 8, width of the program counter.
REQ-002 Parameter REG_AW, default 5, register address width.
REQ-003 Parameter MC_LAT, default 4, EX-stage cycles a multi-cycle op occupies (2..15).
REQ-004 Port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port rst_i, input, 1, synchronous active-high reset.
REQ-006 Ports id_rs1_i, id_rs2_i, input, REG_AW, source registers of the instruction in ID.
REQ-007 Ports id_use_rs1_i, id_use_rs2_i, id_branch_i, input, 1, operand-valid flags and a flag marking an ID-resolved branch/jalr.
REQ-008 Ports ex_rs1_i, ex_rs2_i, input, REG_AW, source registers of the instruction in EX.
REQ-009 Ports ex_rd_i, mem_rd_i, wb_rd_i, input, REG_AW, destinations in EX/MEM/WB.
REQ-010 Ports ex_reg_write_i, ex_mem_read_i, mem_reg_write_i, mem_mem_read_i, wb_reg_write_i, input, 1, stage control flags.
REQ-011 Port ex_multi_i, input, 1, a multi-cycle op has entered EX this cycle.
REQ-012 Ports redirect_i (1) and redirect_pc_i (PC_W), input, taken branch/jal/jalr resolved in ID and its target.
REQ-013 Port pc_o, output, PC_W, current fetch address.
REQ-014 Ports stall_o, ifid_flush_o, idex_bubble_o, exmem_bubble_o, output, 1, pipeline-register controls.
REQ-015 Ports fwd_a_o, fwd_b_o, output, 2, EX operand select: 00 register file, 01 EX/MEM result, 10 MEM/WB result.

Function
REQ-016 FSM states RUN and MC_WAIT; 4-bit down-counter mc_cnt.
REQ-017 In RUN with ex_multi_i=1: next state MC_WAIT, mc_cnt <= MC_LAT-2; MC_LAT=1 is not supported.
REQ-018 In MC_WAIT: stall_o=1 and exmem_bubble_o=1; mc_cnt decrements each cycle; at mc_cnt=0 return to RUN on the next edge.
REQ-019 Source x0 never matches any destination (no hazard, no forward).
REQ-020 Load-use hazard: id_rs1_i or id_rs2_i (when its use flag is set) equals ex_rd_i with ex_mem_read_i=1.
REQ-021 Branch hazard: id_branch_i=1 and a used ID source equals ex_rd_i (ex_reg_write_i=1) or mem_rd_i (mem_mem_read_i=1).
REQ-022 On either hazard in RUN: stall_o=1, idex_bubble_o=1, pc_o held, for exactly the cycles the condition persists.
REQ-023 Priority: rst_i > MC_WAIT > hazard stall > redirect > sequential increment.
REQ-024 Redirect accepted only when stall_o=0: pc_o <= redirect_pc_i, ifid_flush_o=1 the same cycle; a redirect during stall is ignored (ID holds and re-presents it).
REQ-025 Otherwise pc_o <= pc_o + 1, wrapping modulo 2^PC_W.
REQ-026 Forward select: EX/MEM match (mem_reg_write_i, mem_rd_i!=0, not a load) beats MEM/WB match; a MEM-stage load match selects 00 (load-use stall already prevents it).
REQ-027 All controls except pc_o and FSM state are combinational from current inputs/state.

Reset
REQ-028 rst_i=1: pc_o=0, state RUN, mc_cnt=0; all outputs driven to 0 in the reset cycle, overriding a multi-cycle op in progress.

Configuration
REQ-029 Macro PIPE_CTRL_FWD_EN: defined -> REQ-026 forwarding active, hazards per REQ-020/021.
REQ-030 Undefined -> fwd_a_o/fwd_b_o tied 00; any used ID source matching ex_rd_i (ex_reg_write_i) or mem_rd_i (mem_reg_write_i) stalls per REQ-022.

Structure
REQ-031 Shared package pipe_pkg holds the FSM state typedef and the forward-select encodings (FWD_RF, FWD_MEM, FWD_WB).
REQ-032 One sub-module, fwd_sel, computes one 2-bit select; instantiated twice for operands A and B.

Verification
REQ-033 Reset, 5 cycles no stall -> pc_o 0,1,2,3,4,5; PC_W=8 from 255 -> wraps to 0.
REQ-034 ld x5 in EX, ID uses rs1=x5 -> one cycle stall_o=1, idex_bubble_o=1, pc_o held; next cycle released.
REQ-035 ex_multi_i=1 with MC_LAT=4 -> stall_o/exmem_bubble_o high 3 cycles, then RUN.
REQ-036 redirect_i=1, redirect_pc_i=0x40, no stall -> pc_o=0x40 next cycle, ifid_flush_o=1; same with concurrent load-use -> ignored, pc held.
REQ-037 FWD_EN: EX rs1=x3, MEM rd=x3 and WB rd=x3 -> fwd_a_o=01; x0 in all -> 00; undefined -> stall instead.
REQ-038 rst_i asserted in MC_WAIT -> next cycle state RUN, pc_o=0, stall_o=0.
